mcp3002_responder: RTL and testbench

MCP3002_RESPONDER -- requirements
Module: mcp3002_responder

---
 rtl/mcp3002_responder.sv | 117 +++++++++++
 tb/tb_mcp3002_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mcp3002_responder.sv
// mcp3002_responder: MCP3002 SPI ADC emulator driving programmable CH0/CH1 codes
module mcp3002_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_clk,
  input  logic       adc_din,
  input  logic       adc_cs,
  output logic       adc_dout,
  input  logic [9:0] ch0_value,
  input  logic [9:0] ch1_value,
  output logic [9:0] sample_value,
  output logic [2:0] sample_cfg,
  output logic       busy,
  output logic       conv_done
);
  typedef enum logic [2:0] {IDLE, WAIT_START, CFG, NULLBIT, DATA_MSB, DATA_LSB, TAIL} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES:0] sclk_q, cs_q;
  logic [SYNC_STAGES-1:0] din_q;
  logic [3:0] cnt, cnt_n;
  logic [1:0] cfg_q, cfg_n;
  logic [2:0] scfg_n;
  logic [9:0] val_n, code;
  logic [10:0] d01, d10;
  logic dout_n, done_n, s_rise, s_fall, c_rise, c_fall, din;
  assign s_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign s_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign c_rise = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign c_fall = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign din = din_q[SYNC_STAGES-1];
  assign busy = state inside {CFG, NULLBIT, DATA_MSB, DATA_LSB};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      cs_q <= '1;
      din_q <= '0;
      state <= IDLE;
      cnt <= '0;
      cfg_q <= '0;
      sample_cfg <= '0;
      sample_value <= '0;
      adc_dout <= 1'b1;
      conv_done <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], adc_clk};
      cs_q <= {cs_q[SYNC_STAGES-1:0], adc_cs};
      din_q <= {din_q[SYNC_STAGES-2:0], adc_din};
      state <= state_n;
      cnt <= cnt_n;
      cfg_q <= cfg_n;
      sample_cfg <= scfg_n;
      sample_value <= val_n;
      adc_dout <= dout_n;
      conv_done <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cfg_n = cfg_q;
    scfg_n = sample_cfg;
    val_n = sample_value;
    dout_n = adc_dout;
    d01 = {1'b0, ch0_value} - {1'b0, ch1_value};
    d10 = {1'b0, ch1_value} - {1'b0, ch0_value};
    code = sample_cfg[2] ? (sample_cfg[1] ? ch1_value : ch0_value)
         : sample_cfg[1] ? (d10[10] ? 10'd0 : d10[9:0]) : (d01[10] ? 10'd0 : d01[9:0]);
    if (c_rise) begin
      state_n = IDLE;
      cnt_n = '0;
      dout_n = 1'b1;
    end else
      case (state)
        IDLE: begin
          dout_n = 1'b1;
          state_n = c_fall ? WAIT_START : IDLE;
        end
        WAIT_START:
          if (s_rise && din) begin
            state_n = CFG;
            cnt_n = '0;
          end
        CFG:
          if (s_rise) begin
            cfg_n = {cfg_q[0], din};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd2) begin
              scfg_n = {cfg_q, din};
              state_n = NULLBIT;
            end
          end
        NULLBIT:
          if (s_fall) begin
            dout_n = 1'b0;
            val_n = code;
            cnt_n = 4'd9;
            state_n = DATA_MSB;
          end
        DATA_MSB:
          if (s_fall) begin
            dout_n = sample_value[cnt];
            cnt_n = cnt == 4'd0 ? 4'd1 : cnt - 4'd1;
            if (cnt == 4'd0) state_n = sample_cfg[0] ? TAIL : DATA_LSB;
          end
        DATA_LSB:
          if (s_fall) begin
            dout_n = sample_value[cnt];
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd9) state_n = TAIL;
          end
        TAIL: dout_n = s_fall ? 1'b0 : adc_dout;
        default: state_n = IDLE;
      endcase
    done_n = (state_n == TAIL) && (state != TAIL);
  end
endmodule

// File: tb/tb_mcp3002_responder.sv
// tb_mcp3002_responder: directed vector bench for mcp3002_responder
module tb_mcp3002_responder;
  localparam int S = 2;
  localparam int HALF = 80;
  logic clk = 1'b0, rst = 1'b1, adc_clk = 1'b0, adc_din = 1'b0, adc_cs = 1'b1;
  logic adc_dout, busy, conv_done;
  logic [9:0] ch0_value = '0, ch1_value = '0, sample_value;
  logic [2:0] sample_cfg;
  int checks = 0, fails = 0, done_cnt = 0;
  typedef struct {
    logic [2:0] cfg;
    logic [9:0] c0, c1, ev;
  } vec_t;
  vec_t vt [8];
  always #5 clk = ~clk;
  always @(posedge clk) if (conv_done) done_cnt <= done_cnt + 1;
  mcp3002_responder #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_din(adc_din), .adc_cs(adc_cs),
    .adc_dout(adc_dout), .ch0_value(ch0_value), .ch1_value(ch1_value),
    .sample_value(sample_value), .sample_cfg(sample_cfg), .busy(busy), .conv_done(conv_done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic xfer(input int lz, input logic [2:0] cfg, input int n, input int chg_at,
                      input logic [9:0] chg_val, output logic [31:0] rx);
    logic [3:0] sh;
    sh = {1'b1, cfg};
    rx = '0;
    for (int i = 0; i < n; i++) begin
      if (i >= lz && i < lz + 4) begin
        adc_din = sh[3];
        sh = sh << 1;
      end else adc_din = 1'b0;
      #HALF adc_clk = 1'b1;
      rx = {rx[30:0], adc_dout};
      if (i == chg_at) ch0_value = chg_val;
      #HALF adc_clk = 1'b0;
    end
  endtask
  task automatic run_frame(input string nm, input int lz, input logic [2:0] cfg, input logic [9:0] ev,
                           input int chg_at, input logic [9:0] chg_val);
    int m, d0;
    logic [31:0] rx, ex, mk;
    m = cfg[0] ? 12 : 21;
    ex = {22'd0, ev};
    if (!cfg[0]) for (int i = 1; i < 10; i++) ex = {ex[30:0], ev[i]};
    ex = {ex[30:0], 1'b0};
    mk = (32'd1 << m) - 32'd1;
    d0 = done_cnt;
    if (adc_cs) begin
      adc_cs = 1'b0;
      #HALF;
    end
    xfer(lz, cfg, lz + 4 + m, chg_at, chg_val, rx);
    adc_cs = 1'b1;
    #HALF;
    chk({nm, " dout_stream"}, rx & mk, ex);
    chk({nm, " sample_value"}, sample_value, ev);
    chk({nm, " sample_cfg"}, sample_cfg, cfg);
    chk({nm, " conv_done_count"}, done_cnt - d0, 1);
    chk({nm, " busy_after"}, busy, 0);
    chk({nm, " dout_idle"}, adc_dout, 1);
  endtask
  initial begin
    logic [31:0] rx;
    int d0;
    vt[0] = '{3'b101, 10'h2A5, 10'h0F0, 10'h2A5};
    vt[1] = '{3'b110, 10'h3FF, 10'h001, 10'h001};
    vt[2] = '{3'b001, 10'h100, 10'h180, 10'h000};
    vt[3] = '{3'b011, 10'h100, 10'h180, 10'h080};
    vt[4] = '{3'b000, 10'h3FF, 10'h000, 10'h3FF};
    vt[5] = '{3'b010, 10'h155, 10'h155, 10'h000};
    vt[6] = '{3'b111, 10'h000, 10'h2C3, 10'h2C3};
    vt[7] = '{3'b001, 10'h200, 10'h0FF, 10'h101};
    #30;
    chk("rst dout", adc_dout, 1);
    chk("rst busy", busy, 0);
    chk("rst conv_done", conv_done, 0);
    chk("rst sample_value", sample_value, 0);
    chk("rst sample_cfg", sample_cfg, 0);
    rst = 1'b0;
    #HALF;
    adc_din = 1'b1;
    repeat (4) begin
      #HALF adc_clk = 1'b1;
      #HALF adc_clk = 1'b0;
    end
    #HALF;
    chk("cs_high_sclk busy", busy, 0);
    chk("cs_high_sclk dout", adc_dout, 1);
    for (int k = 0; k < 8; k++) begin
      ch0_value = vt[k].c0;
      ch1_value = vt[k].c1;
      run_frame($sformatf("vec%0d", k), 0, vt[k].cfg, vt[k].ev, -1, 10'd0);
    end
    ch0_value = 10'h000;
    ch1_value = 10'h3FF;
    d0 = done_cnt;
    adc_cs = 1'b0;
    #HALF;
    xfer(0, 3'b101, 9, -1, 10'd0, rx);
    chk("abort busy_mid", busy, 1);
    @(posedge clk);
    #2 adc_cs = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    chk("abort dout", adc_dout, 1);
    chk("abort busy", busy, 0);
    #HALF;
    chk("abort conv_done_count", done_cnt - d0, 0);
    chk("abort sample_cfg_kept", sample_cfg, 3'b101);
    run_frame("after_abort", 0, 3'b110, 10'h3FF, -1, 10'd0);
    ch0_value = 10'h2A5;
    d0 = done_cnt;
    adc_cs = 1'b0;
    #HALF;
    xfer(0, 3'b101, 7, -1, 10'd0, rx);
    chk("midrst busy_mid", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst dout", adc_dout, 1);
    chk("midrst busy", busy, 0);
    chk("midrst sample_value", sample_value, 0);
    chk("midrst sample_cfg", sample_cfg, 0);
    chk("midrst conv_done", conv_done, 0);
    #40 rst = 1'b0;
    #HALF;
    xfer(3, 3'b000, 3, -1, 10'd0, rx);
    #HALF;
    chk("midrst lz busy", busy, 0);
    chk("midrst lz dout", adc_dout, 1);
    chk("midrst lz sample_value", sample_value, 0);
    chk("midrst conv_done_count", done_cnt - d0, 0);
    adc_cs = 1'b1;
    #HALF;
    run_frame("after_rst", 3, 3'b101, 10'h2A5, -1, 10'd0);
    ch0_value = 10'h2A5;
    run_frame("b2b_old", 0, 3'b101, 10'h2A5, 4, 10'h15A);
    run_frame("b2b_new", 0, 3'b101, 10'h15A, -1, 10'd0);
    ch0_value = 10'h100;
    ch1_value = 10'h180;
    adc_din = 1'b1;
    adc_cs = 1'b0;
    adc_clk = 1'b1;
    #HALF adc_clk = 1'b0;
    #HALF;
    run_frame("cs_with_sclk", 0, 3'b011, 10'h080, -1, 10'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
